test_state_sequencer: RTL and testbench
=======================================

// Module: test_state_sequencer
// PURPOSE
//   Parametrised, sequential game-state stimulus source for UART/memory and display bring-up.
//   Generates a valid sudoku board cell by cell and presents it with masks, colours, cursor, errors,
//   score and timer as one snapshot bundle.
//   Plays scripted scenarios over time (running timer, error walk, victory) and hands each snapshot
//   to the consumer over a valid/ready handshake.
//   Sits in place of the game core, feeding the UART serializer.
// PARAMETERS
//   B         3           box side; grid side N=B*B (legal: 2,3); CELLS=N*N
//   TICK_DIV  50_000_000  clk cycles per game second (1 for simulation)
//   TIME_W    11          width of time_in_seconds
// PORTS
//   clk              in   1          system clock
//   rst_n            in   1          reset; asynchronous, active-low
//   start            in   1          pulse: latch scenario and regenerate board
//   scenario         in   2          0=PLAYING timer, 1=VICTORY, 2=ERROR_WALK, 3=HARD board
//   snap_valid       out  1          snapshot bundle stable and offered
//   snap_ready       in   1          consumer accepts snapshot
//   busy             out  1          high in GEN state
//   current_state    out  3          101 playing, 110 victory, 111 defeat, 000 idle
//   game_dificulty   out  1          1 for scenario 3, else 0
//   full_board       out  4*CELLS    cell (r,c) at bits [4*(r*N+c)+:4], 0 = blank
//   colors           out  2*CELLS    00 blank, 01 given, 10 entered, 11 error
//   position         out  8          {row[3:0], col[3:0]} cursor
//   errors           out  2          error count, saturates at 3
//   selected_number  out  4          value at cursor, 0 if blank
//   victory_condition out 1          1 only in VICTORY
//   score            out  7          100 - 10*errors, clamped at 0
//   time_in_seconds  out  TIME_W     game seconds, saturating
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, tick prescaler 0.
//   FSM IDLE -> GEN on start. GEN -> PRESENT after CELLS cycles. PRESENT -> RUN when snap_valid&&snap_ready.
//   RUN -> PRESENT on a tick producing an update. start in any state -> GEN.
//     In GEN, a start restarts index 0.
//   GEN: one cell per clk, index i=0..CELLS-1, r=i/N, c=i%N.
//     val=((r*B + r/B + c) mod N)+1.
//     Blank if (i mod M)==0, M=3 for scenario 3, else M=5.
//     Blank: board nibble 0, colour 00. Else value, colour 01.
//   Last cell written on cycle CELLS after start; snap_valid rises next cycle.
//   On GEN entry: errors=0, time=0, position=0, prescaler=0.
//     current_state=101, or 110 for scenario 1. victory=1 only for scenario 1.
//   PRESENT: all bundle outputs frozen while snap_valid && !snap_ready; snap_valid drops cycle after accept.
//   RUN: prescaler counts 0..TICK_DIV-1; tick on wrap. Prescaler also counts in PRESENT.
//     Ticks in PRESENT are held pending, max 1 pending.
//   Tick, scenario 0/3: time++ (hold at 2^TIME_W-1) -> PRESENT.
//   Tick, scenario 2, state 101: cursor col++ (wrap N-1 -> 0 and row++, row wraps to 0).
//     If new cell blank: write (val mod N)+1, colour 11, errors++. Otherwise colour 10.
//     errors==3 -> current_state=111. -> PRESENT.
//   Scenario 1, or state 111: ticks ignored, FSM stays RUN.
//   selected_number and score recomputed registered, same cycle as the bundle update.
//   Unused high nibbles of the 8-bit position fields are 0.
// TESTING
//   T1 B=3, TICK_DIV=4: reset low mid-GEN -> all outputs 0, IDLE; snap_valid 0 until next start.
//   T2 start, scenario=0 -> busy 81 cycles; snap_valid at cycle 82.
//     Cell(0,0)=0/00; cell(0,1)=2/01; cell(1,0)=4/01; state 101.
//   T3 scenario 0, snap_ready held 1 -> new snapshot every 4 cycles with time 1,2,3...
//     Force time to 2047 -> stays 2047.
//   T4 snap_ready held 0 for 20 cycles -> bundle unchanged, one tick pending.
//     Ready=1 -> accept, then next snapshot with time+1 only.
//   T5 scenario 2 -> cursor 00 -> 01 -> ...; 3 blank hits -> errors 3, state 111, score 70.
//     Further ticks produce no snapshot.
//   T6 scenario 1 -> state 110, victory 1, score 100.
//     B=2 build -> 16 cells, board width 64, GEN 16 cycles.

Source files
------------

// File: rtl/test_state_sequencer.sv
// Scripted sudoku game-state source: builds a valid board cell by cell, then plays a timer,
// error-walk or victory scenario and offers each resulting snapshot to a consumer.
module test_state_sequencer #(
    parameter int B        = 3,
    parameter int TICK_DIV = 50_000_000,
    parameter int TIME_W   = 11,
    localparam int N       = B * B,
    localparam int CELLS   = N * N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           scenario,
    output logic                 snap_valid,
    input  logic                 snap_ready,
    output logic                 busy,
    output logic [2:0]           current_state,
    output logic                 game_dificulty,
    output logic [4*CELLS-1:0]   full_board,
    output logic [2*CELLS-1:0]   colors,
    output logic [7:0]           position,
    output logic [1:0]           errors,
    output logic [3:0]           selected_number,
    output logic                 victory_condition,
    output logic [6:0]           score,
    output logic [TIME_W-1:0]    time_in_seconds,
    output logic [1:0]           dbg_state
);

    // Handshake: snap_valid stays high with the bundle frozen until the cycle snap_valid && snap_ready
    // is sampled; that edge is the transfer, and snap_valid is low in the following cycle.

    localparam int IDX_W = $clog2(CELLS + 1);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [2:0] ST_PLAY = 3'b101;
    localparam logic [2:0] ST_WIN  = 3'b110;
    localparam logic [2:0] ST_LOSE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GEN     = 2'd1,
        S_PRESENT = 2'd2,
        S_RUN     = 2'd3
    } fsm_t;

    fsm_t               fsm_q;
    logic [1:0]         scen_q;
    logic [IDX_W-1:0]   gen_idx_q;
    logic [3:0]         gen_row_q;
    logic [3:0]         gen_col_q;
    logic [2:0]         gen_mod_q;
    logic [PRE_W-1:0]   pre_q;
    logic               pend_q;
    logic               snap_valid_q;
    logic [2:0]         cur_state_q;
    logic               difficulty_q;
    logic [4*CELLS-1:0] board_q;
    logic [2*CELLS-1:0] colors_q;
    logic [3:0]         pos_row_q;
    logic [3:0]         pos_col_q;
    logic [1:0]         errors_q;
    logic [3:0]         sel_q;
    logic               victory_q;
    logic [6:0]         score_q;
    logic [TIME_W-1:0]  time_q;

    function automatic logic [3:0] cell_val(input logic [3:0] r, input logic [3:0] c);
        int s;
        s = int'(r) * B + int'(r) / B + int'(c);
        return 4'((s % N) + 1);
    endfunction

    function automatic logic [6:0] score_of(input logic [1:0] e);
        int s;
        s = 100 - 10 * int'(e);
        return (s < 0) ? 7'd0 : 7'(s);
    endfunction

    logic             tick;
    logic [PRE_W-1:0] pre_d;
    logic [3:0]       walk_row_d;
    logic [3:0]       walk_col_d;
    logic [3:0]       walk_cur;
    logic [3:0]       walk_val_d;
    logic             walk_blank;
    int               walk_i;
    logic [1:0]       errors_d;
    logic [2:0]       gen_mod_last;
    logic             gen_blank;
    logic             is_timer;
    logic             is_walk;

    always_comb begin
        tick       = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d      = tick ? '0 : pre_q + 1'b1;
        walk_row_d = pos_row_q;
        walk_col_d = pos_col_q + 4'd1;
        if (pos_col_q == 4'(N - 1)) begin
            walk_col_d = 4'd0;
            walk_row_d = (pos_row_q == 4'(N - 1)) ? 4'd0 : pos_row_q + 4'd1;
        end
        walk_i     = int'(walk_row_d) * N + int'(walk_col_d);
        walk_cur   = board_q[4*walk_i +: 4];
        walk_blank = (walk_cur == 4'd0);
        // A blank cell receives a deliberately wrong digit: the solution value rotated by one.
        walk_val_d = walk_blank ? 4'((int'(cell_val(walk_row_d, walk_col_d)) % N) + 1) : walk_cur;
        errors_d   = (errors_q == 2'd3) ? 2'd3 : errors_q + 2'd1;
        gen_mod_last = (scen_q == 2'd3) ? 3'd2 : 3'd4;
        gen_blank  = (gen_mod_q == 3'd0);
        is_timer   = (scen_q == 2'd0) || (scen_q == 2'd3);
        is_walk    = (scen_q == 2'd2) && (cur_state_q == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= S_IDLE;
            scen_q       <= 2'd0;
            gen_idx_q    <= '0;
            gen_row_q    <= 4'd0;
            gen_col_q    <= 4'd0;
            gen_mod_q    <= 3'd0;
            pre_q        <= '0;
            pend_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            cur_state_q  <= 3'b000;
            difficulty_q <= 1'b0;
            board_q      <= '0;
            colors_q     <= '0;
            pos_row_q    <= 4'd0;
            pos_col_q    <= 4'd0;
            errors_q     <= 2'd0;
            sel_q        <= 4'd0;
            victory_q    <= 1'b0;
            score_q      <= 7'd0;
            time_q       <= '0;
        end else if (start) begin
            fsm_q        <= S_GEN;
            scen_q       <= scenario;
            gen_idx_q    <= '0;
            gen_row_q    <= 4'd0;
            gen_col_q    <= 4'd0;
            gen_mod_q    <= 3'd0;
            pre_q        <= '0;
            pend_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            cur_state_q  <= (scenario == 2'd1) ? ST_WIN : ST_PLAY;
            difficulty_q <= (scenario == 2'd3);
            victory_q    <= (scenario == 2'd1);
            pos_row_q    <= 4'd0;
            pos_col_q    <= 4'd0;
            errors_q     <= 2'd0;
            sel_q        <= 4'd0;
            score_q      <= score_of(2'd0);
            time_q       <= '0;
        end else begin
            case (fsm_q)
                S_GEN: begin
                    board_q[4*int'(gen_idx_q) +: 4]  <= gen_blank ? 4'd0 : cell_val(gen_row_q, gen_col_q);
                    colors_q[2*int'(gen_idx_q) +: 2] <= gen_blank ? 2'b00 : 2'b01;
                    gen_mod_q <= (gen_mod_q == gen_mod_last) ? 3'd0 : gen_mod_q + 3'd1;
                    if (gen_col_q == 4'(N - 1)) begin
                        gen_col_q <= 4'd0;
                        gen_row_q <= gen_row_q + 4'd1;
                    end else begin
                        gen_col_q <= gen_col_q + 4'd1;
                    end
                    if (gen_idx_q == IDX_W'(CELLS - 1)) begin
                        fsm_q        <= S_PRESENT;
                        snap_valid_q <= 1'b1;
                    end else begin
                        gen_idx_q <= gen_idx_q + 1'b1;
                    end
                end
                S_PRESENT: begin
                    pre_q <= pre_d;
                    if (tick) pend_q <= 1'b1;
                    if (snap_ready) begin
                        snap_valid_q <= 1'b0;
                        fsm_q        <= S_RUN;
                    end
                end
                S_RUN: begin
                    pre_q <= pre_d;
                    if (tick || pend_q) begin
                        pend_q <= 1'b0;
                        if (is_timer) begin
                            time_q       <= (&time_q) ? time_q : time_q + 1'b1;
                            snap_valid_q <= 1'b1;
                            fsm_q        <= S_PRESENT;
                        end else if (is_walk) begin
                            pos_row_q <= walk_row_d;
                            pos_col_q <= walk_col_d;
                            sel_q     <= walk_val_d;
                            if (walk_blank) begin
                                board_q[4*walk_i +: 4]  <= walk_val_d;
                                colors_q[2*walk_i +: 2] <= 2'b11;
                                errors_q <= errors_d;
                                score_q  <= score_of(errors_d);
                                if (errors_d == 2'd3) cur_state_q <= ST_LOSE;
                            end else begin
                                colors_q[2*walk_i +: 2] <= 2'b10;
                            end
                            snap_valid_q <= 1'b1;
                            fsm_q        <= S_PRESENT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign snap_valid        = snap_valid_q;
    assign busy              = (fsm_q == S_GEN);
    assign current_state     = cur_state_q;
    assign game_dificulty    = difficulty_q;
    assign full_board        = board_q;
    assign colors            = colors_q;
    assign position          = {pos_row_q, pos_col_q};
    assign errors            = errors_q;
    assign selected_number   = sel_q;
    assign victory_condition = victory_q;
    assign score             = score_q;
    assign time_in_seconds   = time_q;
    assign dbg_state         = fsm_q;

endmodule

// File: tb/tb_test_state_sequencer.sv
// Directed bench for test_state_sequencer: B=3 main instance plus a B=2 instance sharing stimulus.
module tb_test_state_sequencer;

    localparam int CELLS  = 81;
    localparam int CELLS2 = 16;
    localparam int TW     = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic snap_ready = 1'b0;
    logic [1:0] scenario = 2'd0;

    logic                 snap_valid, busy, game_dificulty, victory_condition;
    logic [2:0]           current_state;
    logic [4*CELLS-1:0]   full_board;
    logic [2*CELLS-1:0]   colors;
    logic [7:0]           position;
    logic [1:0]           errors, dbg_state;
    logic [3:0]           selected_number;
    logic [6:0]           score;
    logic [TW-1:0]        time_in_seconds;

    logic                 snap_valid2, busy2, game_dificulty2, victory_condition2;
    logic [2:0]           current_state2;
    logic [4*CELLS2-1:0]  full_board2;
    logic [2*CELLS2-1:0]  colors2;
    logic [7:0]           position2;
    logic [1:0]           errors2, dbg_state2;
    logic [3:0]           selected_number2;
    logic [6:0]           score2;
    logic [TW-1:0]        time_in_seconds2;

    int n_cmp = 0;
    int n_fail = 0;

    test_state_sequencer #(.B(3), .TICK_DIV(4), .TIME_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scenario(scenario),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .busy(busy),
        .current_state(current_state), .game_dificulty(game_dificulty),
        .full_board(full_board), .colors(colors), .position(position),
        .errors(errors), .selected_number(selected_number),
        .victory_condition(victory_condition), .score(score),
        .time_in_seconds(time_in_seconds), .dbg_state(dbg_state)
    );

    test_state_sequencer #(.B(2), .TICK_DIV(4), .TIME_W(TW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .scenario(scenario),
        .snap_valid(snap_valid2), .snap_ready(snap_ready), .busy(busy2),
        .current_state(current_state2), .game_dificulty(game_dificulty2),
        .full_board(full_board2), .colors(colors2), .position(position2),
        .errors(errors2), .selected_number(selected_number2),
        .victory_condition(victory_condition2), .score(score2),
        .time_in_seconds(time_in_seconds2), .dbg_state(dbg_state2)
    );

    always #5 clk = ~clk;

    logic out_any, out_any2;
    assign out_any = |{snap_valid, busy, current_state, game_dificulty, full_board, colors, position,
                       errors, selected_number, victory_condition, score, time_in_seconds, dbg_state};
    assign out_any2 = |{snap_valid2, busy2, current_state2, game_dificulty2, full_board2, colors2, position2,
                        errors2, selected_number2, victory_condition2, score2, time_in_seconds2, dbg_state2};

    task automatic do_start(input logic [1:0] sc);
        @(negedge clk);
        scenario = sc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen = snap_valid;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            seen = snap_valid;
        end
    endtask

    task automatic test_reset();
        bit saw;
        @(negedge clk);
        n_cmp++; if (out_any !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: got %0b expected 0", out_any); end
        n_cmp++; if (out_any2 !== 1'b0) begin n_fail++; $display("FAIL reset_outputs_b2: got %0b expected 0", out_any2); end
        rst_n = 1'b1;
        do_start(2'd0);
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_gen_busy: got %0b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_any !== 1'b0) begin n_fail++; $display("FAIL async_reset_outputs: got %0b expected 0", out_any); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL async_reset_idle: got %0d expected 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (snap_valid || busy) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %0b expected 0", saw); end
    endtask

    task automatic test_gen();
        int n;
        snap_ready = 1'b0;
        do_start(2'd0);
        n = 0;
        while (busy && n < 200) begin n++; @(negedge clk); end
        n_cmp++; if (n != 81) begin n_fail++; $display("FAIL gen_busy_cycles: got %0d expected 81", n); end
        n_cmp++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL gen_valid_rise: got %0b expected 1", snap_valid); end
        n_cmp++; if ({full_board[3:0], colors[1:0]} !== 6'b0000_00) begin n_fail++; $display("FAIL cell00: got %0h expected 0", {full_board[3:0], colors[1:0]}); end
        n_cmp++; if ({full_board[7:4], colors[3:2]} !== 6'b0010_01) begin n_fail++; $display("FAIL cell01: got %0h expected 09", {full_board[7:4], colors[3:2]}); end
        n_cmp++; if ({full_board[39:36], colors[19:18]} !== 6'b0100_01) begin n_fail++; $display("FAIL cell10: got %0h expected 11", {full_board[39:36], colors[19:18]}); end
        n_cmp++; if ({full_board[319:316], colors[159:158]} !== 6'b0111_01) begin n_fail++; $display("FAIL cell87: got %0h expected 1d", {full_board[319:316], colors[159:158]}); end
        n_cmp++; if ({full_board[323:320], colors[161:160]} !== 6'b0000_00) begin n_fail++; $display("FAIL cell88: got %0h expected 0", {full_board[323:320], colors[161:160]}); end
        n_cmp++; if (current_state !== 3'b101) begin n_fail++; $display("FAIL gen_state: got %0b expected 101", current_state); end
        n_cmp++; if ({score, errors, time_in_seconds, position, victory_condition, game_dificulty} !== {7'd100, 2'd0, 11'd0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL gen_bundle: got score %0d err %0d time %0d pos %0h", score, errors, time_in_seconds, position);
        end
    endtask

    task automatic test_timer();
        int cyc;
        bit seen;
        snap_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %0b expected 0", snap_valid); end
        for (int k = 1; k <= 4; k++) begin
            wait_valid(10, cyc, seen);
            n_cmp++; if (!seen) begin n_fail++; $display("FAIL timer_snap%0d: got no snapshot expected one", k); end
            n_cmp++; if (time_in_seconds !== TW'(k)) begin n_fail++; $display("FAIL timer_value: got %0d expected %0d", time_in_seconds, k); end
            if (k >= 2) begin
                n_cmp++; if (cyc + 1 != 4) begin n_fail++; $display("FAIL timer_period: got %0d expected 4", cyc + 1); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit seen, changed;
        logic [TW-1:0] t0;
        logic [4*CELLS-1:0] b0;
        logic [2*CELLS-1:0] c0;
        snap_ready = 1'b0;
        wait_valid(10, cyc, seen);
        t0 = time_in_seconds;
        b0 = full_board;
        c0 = colors;
        changed = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!snap_valid || time_in_seconds !== t0 || full_board !== b0 || colors !== c0) changed = 1'b1;
        end
        n_cmp++; if (changed !== 1'b0) begin n_fail++; $display("FAIL bp_frozen: got %0b expected 0", changed); end
        snap_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got %0b expected 0", snap_valid); end
        @(negedge clk);
        n_cmp++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pending_snap: got %0b expected 1", snap_valid); end
        n_cmp++; if (time_in_seconds !== t0 + 1'b1) begin n_fail++; $display("FAIL bp_time_plus1: got %0d expected %0d", time_in_seconds, t0 + 1'b1); end
        @(negedge clk);
        wait_valid(10, cyc, seen);
        n_cmp++; if (time_in_seconds !== t0 + 2'd2) begin n_fail++; $display("FAIL bp_time_plus2: got %0d expected %0d", time_in_seconds, t0 + 2'd2); end
        @(negedge clk);
    endtask

    task automatic test_time_saturation();
        int cyc, bad, exp_t;
        bit seen;
        snap_ready = 1'b1;
        bad = 0;
        wait_valid(10, cyc, seen);
        exp_t = int'(time_in_seconds);
        for (int k = 0; k < 2100 && !(exp_t == 2047 && k > 2050 - 2047 + 2047); k++) begin
            @(negedge clk);
            wait_valid(10, cyc, seen);
            exp_t = (exp_t == 2047) ? 2047 : exp_t + 1;
            if (!seen || int'(time_in_seconds) != exp_t) bad++;
            if (exp_t == 2047 && k > 2060) break;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL time_sequence: got %0d bad snapshots expected 0", bad); end
        n_cmp++; if (time_in_seconds !== 11'd2047) begin n_fail++; $display("FAIL time_saturate: got %0d expected 2047", time_in_seconds); end
        @(negedge clk);
    endtask

    task automatic test_error_walk();
        int cyc, r, c, i, err, given, expv;
        bit seen, blank;
        snap_ready = 1'b1;
        do_start(2'd2);
        wait_valid(200, cyc, seen);
        n_cmp++; if ({position, errors, current_state, score, selected_number} !== {8'h00, 2'd0, 3'b101, 7'd100, 4'd0}) begin
            n_fail++; $display("FAIL walk_start: got pos %0h err %0d st %0b", position, errors, current_state);
        end
        @(negedge clk);
        r = 0; c = 0; err = 0;
        for (int step = 1; step <= 15; step++) begin
            if (c == 8) begin c = 0; r = r + 1; end else c = c + 1;
            i = r * 9 + c;
            blank = (i % 5 == 0);
            given = ((r * 3 + r / 3 + c) % 9) + 1;
            expv = blank ? (given % 9) + 1 : given;
            if (blank) err++;
            wait_valid(10, cyc, seen);
            n_cmp++; if (!seen || position !== {4'(r), 4'(c)}) begin n_fail++; $display("FAIL walk_pos: got %0h expected %0h", position, {4'(r), 4'(c)}); end
            n_cmp++; if (selected_number !== 4'(expv)) begin n_fail++; $display("FAIL walk_sel: got %0d expected %0d", selected_number, expv); end
            n_cmp++; if (errors !== 2'(err) || score !== 7'(100 - 10 * err)) begin n_fail++; $display("FAIL walk_err_score: got %0d/%0d expected %0d/%0d", errors, score, err, 100 - 10 * err); end
            n_cmp++; if (colors[2*i +: 2] !== (blank ? 2'b11 : 2'b10)) begin n_fail++; $display("FAIL walk_colour: got %0b expected %0b", colors[2*i +: 2], blank ? 2'b11 : 2'b10); end
            @(negedge clk);
        end
        n_cmp++; if ({full_board[23:20], full_board[43:40], full_board[63:60]} !== 12'h762) begin
            n_fail++; $display("FAIL walk_written: got %0h expected 762", {full_board[23:20], full_board[43:40], full_board[63:60]});
        end
        n_cmp++; if ({current_state, errors, score} !== {3'b111, 2'd3, 7'd70}) begin
            n_fail++; $display("FAIL walk_defeat: got st %0b err %0d score %0d expected 111/3/70", current_state, errors, score);
        end
        wait_valid(40, cyc, seen);
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL walk_no_more: got %0b expected 0", seen); end
    endtask

    task automatic test_victory();
        int cyc;
        bit seen;
        snap_ready = 1'b1;
        do_start(2'd1);
        wait_valid(200, cyc, seen);
        n_cmp++; if ({current_state, victory_condition, score, errors, game_dificulty} !== {3'b110, 1'b1, 7'd100, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL victory_bundle: got st %0b vic %0b score %0d", current_state, victory_condition, score);
        end
        @(negedge clk);
        wait_valid(40, cyc, seen);
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL victory_no_more: got %0b expected 0", seen); end
    endtask

    task automatic test_hard();
        int cyc;
        bit seen;
        snap_ready = 1'b0;
        do_start(2'd3);
        wait_valid(200, cyc, seen);
        n_cmp++; if ({game_dificulty, current_state, victory_condition} !== {1'b1, 3'b101, 1'b0}) begin
            n_fail++; $display("FAIL hard_flags: got diff %0b st %0b", game_dificulty, current_state);
        end
        n_cmp++; if ({full_board[15:12], colors[7:6], full_board[11:8], colors[5:4]} !== {4'd0, 2'b00, 4'd3, 2'b01}) begin
            n_fail++; $display("FAIL hard_cells: got %0h expected 0d", {full_board[15:12], colors[7:6], full_board[11:8], colors[5:4]});
        end
        snap_ready = 1'b1;
        @(negedge clk);
        wait_valid(10, cyc, seen);
        n_cmp++; if (!seen || time_in_seconds !== 11'd1) begin n_fail++; $display("FAIL hard_timer: got %0d expected 1", time_in_seconds); end
    endtask

    task automatic test_b2();
        int n;
        snap_ready = 1'b0;
        do_start(2'd0);
        n = 0;
        while (busy2 && n < 100) begin n++; @(negedge clk); end
        n_cmp++; if (n != 16) begin n_fail++; $display("FAIL b2_busy_cycles: got %0d expected 16", n); end
        n_cmp++; if (snap_valid2 !== 1'b1) begin n_fail++; $display("FAIL b2_valid: got %0b expected 1", snap_valid2); end
        n_cmp++; if ({full_board2[3:0], full_board2[7:4], full_board2[19:16], full_board2[23:20], full_board2[35:32]} !== 20'h02302) begin
            n_fail++; $display("FAIL b2_cells: got %0h expected 02302", {full_board2[3:0], full_board2[7:4], full_board2[19:16], full_board2[23:20], full_board2[35:32]});
        end
        n_cmp++; if ({colors2[1:0], colors2[9:8], colors2[11:10], colors2[17:16]} !== 8'b00_01_00_01) begin
            n_fail++; $display("FAIL b2_colours: got %0b expected 00010001", {colors2[1:0], colors2[9:8], colors2[11:10], colors2[17:16]});
        end
    endtask

    initial begin
        test_reset();
        test_gen();
        test_timer();
        test_backpressure();
        test_time_saturation();
        test_error_walk();
        test_victory();
        test_hard();
        test_b2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
